// File: rtl/debug_scan_master.sv
// Host-side virtual-JTAG scan initiator: plays UIR, CDR, DR_W x SDR, UDR into the
// debug slave's vji_* port set and hands back the captured TDO bits and IR-out.
module debug_scan_master #(
    parameter int TCK_DIV = 2,
    parameter int DR_W    = 38
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_ir,
    input  logic [DR_W-1:0] cmd_dr,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DR_W-1:0] rsp_dr,
    output logic [1:0]      rsp_ir_out,
    output logic            vji_tck,
    output logic            vji_tdi,
    input  logic            vji_tdo,
    output logic [1:0]      vji_ir_in,
    input  logic [1:0]      vji_ir_out,
    output logic            vji_rti,
    output logic            vji_cdr,
    output logic            vji_sdr,
    output logic            vji_udr,
    output logic            vji_uir
);

    localparam int            KW       = (DR_W > 1) ? $clog2(DR_W) : 1;
    localparam logic [7:0]    DIV_LAST = 8'(TCK_DIV - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(DR_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UIR,
        ST_CDR,
        ST_SDR,
        ST_UDR,
        ST_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      div_q, div_d;
    logic            tck_q, tck_d;
    logic [KW-1:0]   k_q, k_d;
    logic [DR_W-1:0] shift_q, shift_d;
    logic [DR_W-1:0] rsp_dr_q, rsp_dr_d;
    logic [1:0]      rsp_ir_out_q, rsp_ir_out_d;
    logic [1:0]      ir_in_q, ir_in_d;
    logic            tdi_q, tdi_d;
    logic            rti_q, rti_d;
    logic            uir_q, uir_d;
    logic            cdr_q, cdr_d;
    logic            sdr_q, sdr_d;
    logic            udr_q, udr_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            tick, rise, fall;

    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        tck_d        = tck_q;
        k_d          = k_q;
        shift_d      = shift_q;
        rsp_dr_d     = rsp_dr_q;
        rsp_ir_out_d = rsp_ir_out_q;
        ir_in_d      = ir_in_q;
        tdi_d        = tdi_q;
        rti_d        = rti_q;
        uir_d        = uir_q;
        cdr_d        = cdr_q;
        sdr_d        = sdr_q;
        udr_d        = udr_q;
        cmd_ready_d  = cmd_ready_q;
        rsp_valid_d  = rsp_valid_q;
        tick         = (div_q == DIV_LAST);
        rise         = tick && !tck_q;
        fall         = tick && tck_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d     = ST_UIR;
                    cmd_ready_d = 1'b0;
                    shift_d     = cmd_dr;
                    ir_in_d     = cmd_ir;
                    uir_d       = 1'b1;
                    rti_d       = 1'b0;
                    tdi_d       = 1'b0;
                    div_d       = '0;
                    tck_d       = 1'b0;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: begin
                if (tick) begin
                    div_d = '0;
                    tck_d = !tck_q;
                end else begin
                    div_d = div_q + 8'd1;
                end

                // Slave outputs are sampled on the edge that raises TCK
                if (rise) begin
                    if (state_q == ST_UIR) rsp_ir_out_d = vji_ir_out;
                    if (state_q == ST_SDR) rsp_dr_d = {vji_tdo, rsp_dr_q[DR_W-1:1]};
                end

                // Every state change lands on a falling point, so strobes and
                // TDI only ever move at the start of a low phase
                if (fall) begin
                    case (state_q)
                        ST_UIR: begin
                            state_d = ST_CDR;
                            uir_d   = 1'b0;
                            cdr_d   = 1'b1;
                        end
                        ST_CDR: begin
                            state_d = ST_SDR;
                            cdr_d   = 1'b0;
                            sdr_d   = 1'b1;
                            k_d     = '0;
                            tdi_d   = shift_q[0];
                            shift_d = shift_q >> 1;
                        end
                        ST_SDR: begin
                            if (k_q == K_LAST) begin
                                state_d = ST_UDR;
                                sdr_d   = 1'b0;
                                udr_d   = 1'b1;
                                tdi_d   = 1'b0;
                            end else begin
                                k_d     = k_q + KW'(1);
                                tdi_d   = shift_q[0];
                                shift_d = shift_q >> 1;
                            end
                        end
                        ST_UDR: begin
                            state_d     = ST_RESP;
                            udr_d       = 1'b0;
                            rti_d       = 1'b1;
                            rsp_valid_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            div_q        <= '0;
            tck_q        <= 1'b0;
            k_q          <= '0;
            shift_q      <= '0;
            rsp_dr_q     <= '0;
            rsp_ir_out_q <= '0;
            ir_in_q      <= '0;
            tdi_q        <= 1'b0;
            rti_q        <= 1'b1;
            uir_q        <= 1'b0;
            cdr_q        <= 1'b0;
            sdr_q        <= 1'b0;
            udr_q        <= 1'b0;
            cmd_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            tck_q        <= tck_d;
            k_q          <= k_d;
            shift_q      <= shift_d;
            rsp_dr_q     <= rsp_dr_d;
            rsp_ir_out_q <= rsp_ir_out_d;
            ir_in_q      <= ir_in_d;
            tdi_q        <= tdi_d;
            rti_q        <= rti_d;
            uir_q        <= uir_d;
            cdr_q        <= cdr_d;
            sdr_q        <= sdr_d;
            udr_q        <= udr_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_dr     = rsp_dr_q;
    assign rsp_ir_out = rsp_ir_out_q;
    assign vji_tck    = tck_q;
    assign vji_tdi    = tdi_q;
    assign vji_ir_in  = ir_in_q;
    assign vji_rti    = rti_q;
    assign vji_uir    = uir_q;
    assign vji_cdr    = cdr_q;
    assign vji_sdr    = sdr_q;
    assign vji_udr    = udr_q;

endmodule

// File: tb/tb_debug_scan_master.sv
// Self-checking bench for debug_scan_master: directed and randomized scans against
// a TDI/TDO bit-list model, plus a TCK_DIV=1 instance for strobe ordering.
module tb_debug_scan_master;

    localparam int DR_W     = 38;
    localparam int LAT_MAIN = (DR_W + 3) * 2 * 2 + 1;
    localparam int LAT_FAST = (DR_W + 3) * 2 * 1 + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_n;
    logic            cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [1:0]      cmd_ir, rsp_ir_out, vji_ir_in, vji_ir_out;
    logic [DR_W-1:0] cmd_dr, rsp_dr;
    logic            vji_tck, vji_tdi, vji_tdo, vji_rti, vji_cdr, vji_sdr, vji_udr, vji_uir;

    logic            f_cmd_valid, f_cmd_ready, f_rsp_valid, f_rsp_ready;
    logic [1:0]      f_cmd_ir, f_rsp_ir_out, f_ir_in, f_ir_out;
    logic [DR_W-1:0] f_cmd_dr, f_rsp_dr;
    logic            f_tck, f_tdi, f_tdo, f_rti, f_cdr, f_sdr, f_udr, f_uir;

    int              checks = 0;
    int              failures = 0;
    logic            loop_mode;
    logic [DR_W-1:0] tdo_pat;
    int              rise_cnt = 0, sdr_rises = 0, inv_bad = 0, align_bad = 0;
    int              rise_base, sdr_base, tdi_base, sdr_off;
    logic            tdi_log[$];
    logic [3:0]      f_codes[$];

    debug_scan_master #(.TCK_DIV(2), .DR_W(DR_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dr(rsp_dr), .rsp_ir_out(rsp_ir_out),
        .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
        .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out), .vji_rti(vji_rti),
        .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_uir(vji_uir)
    );

    debug_scan_master #(.TCK_DIV(1), .DR_W(DR_W)) dut_fast (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(f_cmd_valid), .cmd_ready(f_cmd_ready), .cmd_ir(f_cmd_ir), .cmd_dr(f_cmd_dr),
        .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_dr(f_rsp_dr), .rsp_ir_out(f_rsp_ir_out),
        .vji_tck(f_tck), .vji_tdi(f_tdi), .vji_tdo(f_tdo),
        .vji_ir_in(f_ir_in), .vji_ir_out(f_ir_out), .vji_rti(f_rti),
        .vji_cdr(f_cdr), .vji_sdr(f_sdr), .vji_udr(f_udr), .vji_uir(f_uir)
    );

    // Slave model: either loopback, or the k-th shift-DR rise of the scan sees tdo_pat[k]
    assign sdr_off = sdr_rises - sdr_base;
    assign vji_tdo = loop_mode ? vji_tdi
                   : ((sdr_off >= 0 && sdr_off < DR_W) ? tdo_pat[sdr_off[5:0]] : 1'b0);
    assign f_tdo   = f_tdi;

    always @(posedge vji_tck) begin
        rise_cnt++;
        if (vji_sdr) begin
            tdi_log.push_back(vji_tdi);
            sdr_rises++;
        end
    end

    always @(posedge f_tck) f_codes.push_back({f_uir, f_cdr, f_sdr, f_udr});

    function automatic bit strobesLegal(input logic u, c, s, d, r);
        int n;
        n = int'(u) + int'(c) + int'(s) + int'(d);
        return r ? (n == 0) : (n == 1);
    endfunction

    // Records cycles breaking the one-strobe rule or changing pins away from a falling point
    logic [8:0] prev_sig;
    logic       prev_tck, prev_rti, prev_ok = 1'b0;
    always @(negedge clk) begin
        if (reset_n) begin
            if (!strobesLegal(vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti)) inv_bad++;
            if (!strobesLegal(f_uir, f_cdr, f_sdr, f_udr, f_rti)) inv_bad++;
            if (prev_ok && {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, vji_tdi, vji_ir_in} !== prev_sig
                && !(prev_tck && !vji_tck) && !prev_rti)
                align_bad++;
            prev_sig = {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, vji_tdi, vji_ir_in};
            prev_tck = vji_tck;
            prev_rti = vji_rti;
            prev_ok  = 1'b1;
        end else begin
            prev_ok = 1'b0;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        checkOutput({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        checkOutput({tag, "_rsp_dr"}, 64'(rsp_dr), 64'd0);
        checkOutput({tag, "_rsp_ir_out"}, 64'(rsp_ir_out), 64'd0);
        checkOutput({tag, "_tck_tdi_irin"}, 64'({vji_tck, vji_tdi, vji_ir_in}), 64'd0);
        checkOutput({tag, "_strobes_rti"}, 64'({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}), 64'b00001);
    endtask

    task automatic markScan();
        rise_base = rise_cnt;
        sdr_base  = sdr_rises;
        tdi_base  = tdi_log.size();
    endtask

    // Called #1 after the accepting edge: block must be busy, then garbage is
    // driven on the command port to prove the latched values are used
    task automatic afterAccept(input logic [1:0] ir);
        checkOutput("cmd_ready_busy", 64'(cmd_ready), 64'd0);
        cmd_valid = 1'b1;
        cmd_dr    = '1;
        cmd_ir    = ~ir;
    endtask

    task automatic applyStimulus(input logic [1:0] ir, input logic [DR_W-1:0] dr);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_ir    = ir;
        cmd_dr    = dr;
        markScan();
        @(posedge clk);
        #1;
        afterAccept(ir);
    endtask

    task automatic waitResponse(output int lat);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 2000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        cmd_valid = 1'b0;
        checkOutput("rsp_valid_seen", 64'(rsp_valid), 64'd1);
    endtask

    task automatic checkScan(input logic [1:0] ir, input logic [DR_W-1:0] dr,
                             input logic [DR_W-1:0] exp_dr, input logic [1:0] exp_ir_out, input int lat);
        logic [DR_W-1:0] seen;
        int n;
        seen = '0;
        n = tdi_log.size() - tdi_base;
        for (int i = 0; i < DR_W; i++)
            if (i < n) seen[i] = tdi_log[tdi_base + i];
        checkOutput("tdi_count", 64'(n), 64'(DR_W));
        checkOutput("tdi_sequence", 64'(seen), 64'(dr));
        checkOutput("rsp_dr", 64'(rsp_dr), 64'(exp_dr));
        checkOutput("rsp_ir_out", 64'(rsp_ir_out), 64'(exp_ir_out));
        checkOutput("latency", 64'(lat), 64'(LAT_MAIN));
        checkOutput("tck_rises", 64'(rise_cnt - rise_base), 64'(DR_W + 3));
        checkOutput("ir_in_resp", 64'(vji_ir_in), 64'(ir));
        checkOutput("strobes_resp", 64'({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}), 64'b00001);
        checkOutput("strobe_invariant", 64'(inv_bad), 64'd0);
        checkOutput("phase_alignment", 64'(align_bad), 64'd0);
    endtask

    task automatic finishHandshake(input logic [1:0] ir);
        @(posedge clk);
        #1;
        checkOutput("rsp_valid_drop", 64'(rsp_valid), 64'd0);
        checkOutput("cmd_ready_back", 64'(cmd_ready), 64'd1);
        checkOutput("ir_in_kept", 64'(vji_ir_in), 64'(ir));
    endtask

    initial begin
        int lat, bad, r0, n;
        logic [1:0]      ir, ir2, iro;
        logic [DR_W-1:0] dr, dr2;
        logic [3:0]      exp_code;

        reset_n = 1'b0;
        cmd_valid = 1'b0; cmd_ir = '0; cmd_dr = '0; rsp_ready = 1'b0; vji_ir_out = '0;
        f_cmd_valid = 1'b0; f_cmd_ir = '0; f_cmd_dr = '0; f_rsp_ready = 1'b1; f_ir_out = 2'b01;
        loop_mode = 1'b1; tdo_pat = '0;
        rise_base = 0; sdr_base = 0; tdi_base = 0;
        repeat (3) @(posedge clk);
        #1;
        checkResetValues("rst");

        @(negedge clk);
        reset_n   = 1'b1;
        rsp_ready = 1'b1;
        bad = 0;
        repeat (200) begin
            @(posedge clk);
            #1;
            if (cmd_ready !== 1'b1 || vji_rti !== 1'b1 || vji_tck !== 1'b0 || rsp_valid !== 1'b0) bad++;
        end
        checkOutput("idle_stable", 64'(bad), 64'd0);

        $display("[TB] loopback scan");
        iro = 2'($urandom);
        vji_ir_out = iro;
        dr = 38'h2A_5A5A_A5A5;
        applyStimulus(2'b10, dr);
        waitResponse(lat);
        checkScan(2'b10, dr, dr, iro, lat);
        finishHandshake(2'b10);

        $display("[TB] randomized scans");
        for (int t = 0; t < 3; t++) begin
            loop_mode  = 1'b0;
            ir         = 2'($urandom);
            dr         = DR_W'({$urandom, $urandom});
            tdo_pat    = DR_W'({$urandom, $urandom});
            iro        = 2'($urandom);
            vji_ir_out = iro;
            applyStimulus(ir, dr);
            waitResponse(lat);
            checkScan(ir, dr, tdo_pat, iro, lat);
            finishHandshake(ir);
        end

        $display("[TB] back-pressure");
        loop_mode = 1'b1;
        rsp_ready = 1'b0;
        ir  = 2'b01;
        dr  = DR_W'({$urandom, $urandom});
        iro = 2'($urandom);
        vji_ir_out = iro;
        applyStimulus(ir, dr);
        waitResponse(lat);
        checkScan(ir, dr, dr, iro, lat);
        ir2 = 2'b11;
        dr2 = DR_W'({$urandom, $urandom});
        cmd_valid = 1'b1;
        cmd_ir    = ir2;
        cmd_dr    = dr2;
        r0  = rise_cnt;
        bad = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (rsp_valid !== 1'b1 || rsp_dr !== dr || cmd_ready !== 1'b0 || vji_tck !== 1'b0) bad++;
        end
        checkOutput("backpressure_stable", 64'(bad), 64'd0);
        checkOutput("backpressure_no_tck", 64'(rise_cnt - r0), 64'd0);
        rsp_ready = 1'b1;
        markScan();
        @(posedge clk);
        #1;
        checkOutput("bp_rsp_valid_drop", 64'(rsp_valid), 64'd0);
        checkOutput("bp_cmd_ready_back", 64'(cmd_ready), 64'd1);
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        afterAccept(ir2);
        waitResponse(lat);
        checkScan(ir2, dr2, dr2, iro, lat);
        rsp_ready = 1'b1;
        finishHandshake(ir2);

        $display("[TB] reset during shift-DR");
        ir = 2'b11;
        dr = DR_W'({$urandom, $urandom});
        applyStimulus(ir, dr);
        n = 0;
        while ((sdr_rises - sdr_base) < 11 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        checkOutput("reached_sdr_k10", 64'((sdr_rises - sdr_base) >= 11), 64'd1);
        @(negedge clk);
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        #1;
        checkResetValues("midrst");
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        bad = 0;
        repeat (200) begin
            @(posedge clk);
            #1;
            if (rsp_valid !== 1'b0 || vji_tck !== 1'b0 || {vji_uir, vji_cdr, vji_sdr, vji_udr} !== 4'b0) bad++;
        end
        checkOutput("after_reset_quiet", 64'(bad), 64'd0);
        iro = 2'($urandom);
        vji_ir_out = iro;
        dr = DR_W'({$urandom, $urandom});
        applyStimulus(2'b10, dr);
        waitResponse(lat);
        checkScan(2'b10, dr, dr, iro, lat);
        finishHandshake(2'b10);

        $display("[TB] TCK_DIV=1 strobe sequencing");
        dr = DR_W'({$urandom, $urandom});
        checkOutput("fast_ir_in_before", 64'(f_ir_in), 64'd0);
        n = f_codes.size();
        @(negedge clk);
        f_cmd_valid = 1'b1;
        f_cmd_ir    = 2'b11;
        f_cmd_dr    = dr;
        @(posedge clk);
        #1;
        f_cmd_valid = 1'b0;
        checkOutput("fast_uir_ir_in", 64'({f_uir, f_ir_in}), 64'b111);
        lat = 1;
        while (f_rsp_valid !== 1'b1 && lat < 2000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("fast_rsp_valid_seen", 64'(f_rsp_valid), 64'd1);
        checkOutput("fast_latency", 64'(lat), 64'(LAT_FAST));
        checkOutput("fast_periods", 64'(f_codes.size() - n), 64'(DR_W + 3));
        bad = 0;
        for (int i = 0; i < DR_W + 3; i++) begin
            if (i == 0)             exp_code = 4'b1000;
            else if (i == 1)        exp_code = 4'b0100;
            else if (i == DR_W + 2) exp_code = 4'b0001;
            else                    exp_code = 4'b0010;
            if (n + i >= f_codes.size() || f_codes[n + i] !== exp_code) bad++;
        end
        checkOutput("fast_strobe_order", 64'(bad), 64'd0);
        checkOutput("fast_rsp_dr", 64'(f_rsp_dr), 64'(dr));
        checkOutput("fast_rsp_ir_out", 64'(f_rsp_ir_out), 64'b01);
        checkOutput("fast_strobe_invariant", 64'(inv_bad), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("fast_cmd_ready_back", 64'(f_cmd_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
